// File: rtl/dap_cmd_dispatcher.sv
// CMSIS-DAP command dispatcher: pops an ID byte, starts one of three handlers, then routes the byte stream to it until done.
// Optional watchdog abort on a stalled command is enabled by defining DAP_DISPATCH_TIMEOUT_EN.
module dap_cmd_dispatcher #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvaild,
    output logic             s_axis_tready,
    output logic [7:0]       cmd_id,
    output logic [2:0]       cmd_start,
    input  logic [2:0]       cmd_done,
    output logic [2:0]       cmd_abort,
    output logic [7:0]       hdl_tdata,
    output logic [2:0]       hdl_tvaild,
    input  logic [2:0]       hdl_tready,
    output logic             busy,
    output logic [1:0]       active_sel,
    output logic [CNT_W-1:0] cmd_count,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cmd_id;
    logic [1:0]       r_sel;
    logic [2:0]       r_cmd_start;
    logic [CNT_W-1:0] r_count;

    logic [1:0] w_dec_sel;
    logic [2:0] w_dec_oh;
    logic [2:0] w_sel_oh;
    logic       w_run;
    logic       w_ready;
    logic       w_done;
    logic       w_accept;
    logic       w_timeout;

    always_comb begin
        w_dec_sel = 2'd0;
        case (s_axis_tdata)
            8'h05, 8'h06, 8'h08: w_dec_sel = 2'd1;
            8'h12, 8'h1D:        w_dec_sel = 2'd2;
            default:             w_dec_sel = 2'd0;
        endcase
    end

    assign w_dec_oh = 3'b001 << w_dec_sel;
    assign w_sel_oh = 3'b001 << r_sel;
    assign w_run    = (r_state == ST_RUN);
    assign w_ready  = |(hdl_tready & w_sel_oh);
    assign w_done   = w_run && |(cmd_done & w_sel_oh);
    assign w_accept = w_run && s_axis_tvaild && w_ready;

    // The ID byte is consumed in IDLE; payload routing is purely combinational in RUN.
    always_comb begin
        s_axis_tready = 1'b0;
        if (r_state == ST_IDLE)
            s_axis_tready = 1'b1;
        else if (w_run)
            s_axis_tready = w_ready;
    end

    assign hdl_tdata  = s_axis_tdata;
    assign hdl_tvaild = (w_run && s_axis_tvaild) ? w_sel_oh : 3'b000;
    assign busy       = (r_state != ST_IDLE);
    assign cmd_id     = r_cmd_id;
    assign cmd_start  = r_cmd_start;
    assign active_sel = r_sel;
    assign cmd_count  = r_count;

`ifdef DAP_DISPATCH_TIMEOUT_EN
    logic [23:0] r_to_cnt;

    // Fires on the cycle the idle count would reach TIMEOUT_CYCLES; a done in that cycle takes priority.
    assign w_timeout   = w_run && !w_done && !w_accept && (r_to_cnt == TIMEOUT_CYCLES - 24'd1);
    assign cmd_abort   = w_timeout ? w_sel_oh : 3'b000;
    assign err_timeout = w_timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= 24'd0;
        end else if (r_state == ST_START || w_accept) begin
            r_to_cnt <= 24'd0;
        end else if (w_run) begin
            r_to_cnt <= r_to_cnt + 24'd1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign cmd_abort   = 3'b000;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cmd_id    <= 8'd0;
            r_sel       <= 2'd0;
            r_cmd_start <= 3'b000;
            r_count     <= '0;
        end else begin
            r_cmd_start <= 3'b000;
            case (r_state)
                ST_IDLE: begin
                    if (s_axis_tvaild) begin
                        r_cmd_id    <= s_axis_tdata;
                        r_sel       <= w_dec_sel;
                        r_cmd_start <= w_dec_oh;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_done) begin
                        r_count <= r_count + 1'b1;
                        r_sel   <= 2'd0;
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_sel   <= 2'd0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_sel   <= 2'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dap_cmd_dispatcher.sv
// Bench for dap_cmd_dispatcher: decode table, directed corner sequences and randomized command traffic.
module tb_dap_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvaild;
    logic        s_axis_tready;
    logic [7:0]  cmd_id;
    logic [2:0]  cmd_start;
    logic [2:0]  cmd_done;
    logic [2:0]  cmd_abort;
    logic [7:0]  hdl_tdata;
    logic [2:0]  hdl_tvaild;
    logic [2:0]  hdl_tready;
    logic        busy;
    logic [1:0]  active_sel;
    logic [15:0] cmd_count;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    dap_cmd_dispatcher #(.TIMEOUT_CYCLES(24'd20), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvaild(s_axis_tvaild), .s_axis_tready(s_axis_tready),
        .cmd_id(cmd_id), .cmd_start(cmd_start), .cmd_done(cmd_done), .cmd_abort(cmd_abort),
        .hdl_tdata(hdl_tdata), .hdl_tvaild(hdl_tvaild), .hdl_tready(hdl_tready),
        .busy(busy), .active_sel(active_sel), .cmd_count(cmd_count), .err_timeout(err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int ref_sel(input logic [7:0] id);
        if (id == 8'h05 || id == 8'h06 || id == 8'h08) return 1;
        if (id == 8'h12 || id == 8'h1D) return 2;
        return 0;
    endfunction

    function automatic logic [2:0] oh(input int s);
        logic [2:0] v;
        v = 3'b000;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Zero-payload command: pop ID, expect start, then the handler finishes on its first RUN cycle.
    task automatic run_empty_cmd(input logic [7:0] id, input int sel, input string nm);
        step(); s_axis_tvaild = 1'b1; s_axis_tdata = id; cmd_done = 3'b000;
        #1 chk({nm, " idle_ready"}, s_axis_tready, 1);
        step(); s_axis_tvaild = 1'b0;
        #1 chk({nm, " start"}, cmd_start, oh(sel));
        chk({nm, " cmd_id"}, cmd_id, id);
        step(); cmd_done = oh(sel);
        #1 chk({nm, " active_sel"}, active_sel, sel);
        step(); cmd_done = 3'b000; exp_count++;
        #1 chk({nm, " busy_after_done"}, busy, 0);
        chk({nm, " count"}, cmd_count, exp_count);
    endtask

    typedef struct {
        logic [7:0] id;
        int         sel;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] stream[$];
        logic [7:0] ids[$];
        int         lens[$];
        int         ptr, k, owner, rcvd, stall, completed, len;
        bit         running, expect_start;

        tbl[0]  = '{8'h05, 1}; tbl[1]  = '{8'h06, 1}; tbl[2]  = '{8'h08, 1};
        tbl[3]  = '{8'h12, 2}; tbl[4]  = '{8'h1D, 2}; tbl[5]  = '{8'h00, 0};
        tbl[6]  = '{8'h8F, 0}; tbl[7]  = '{8'h80, 0}; tbl[8]  = '{8'h9F, 0};
        tbl[9]  = '{8'hFF, 0}; tbl[10] = '{8'h07, 0}; tbl[11] = '{8'h13, 0};

        resetn = 1'b0; s_axis_tdata = 8'h00; s_axis_tvaild = 1'b0;
        cmd_done = 3'b000; hdl_tready = 3'b000;
        #12;
        chk("rst busy", busy, 0);
        chk("rst tready", s_axis_tready, 1);
        chk("rst cmd_id", cmd_id, 0);
        chk("rst active_sel", active_sel, 0);
        chk("rst cmd_count", cmd_count, 0);
        chk("rst cmd_start", cmd_start, 0);
        chk("rst hdl_tvaild", hdl_tvaild, 0);
        chk("rst abort", cmd_abort, 0);
        chk("rst err_timeout", err_timeout, 0);
        step(); resetn = 1'b1;

        for (int i = 0; i < 12; i++)
            run_empty_cmd(tbl[i].id, tbl[i].sel, $sformatf("tbl[%0d]", i));

        // Transfer 0x05 with two payload bytes, done together with the last byte.
        step(); s_axis_tvaild = 1'b1; s_axis_tdata = 8'h05; hdl_tready = 3'b010;
        step(); s_axis_tdata = 8'hAA;
        #1 chk("t1 start", cmd_start, 3'b010);
        chk("t1 start_tready", s_axis_tready, 0);
        chk("t1 start_tvaild", hdl_tvaild, 0);
        step();
        #1 chk("t1 byte0_vld", hdl_tvaild, 3'b010);
        chk("t1 byte0_dat", hdl_tdata, 8'hAA);
        chk("t1 byte0_rdy", s_axis_tready, 1);
        step(); s_axis_tdata = 8'hBB; cmd_done = 3'b010;
        #1 chk("t1 byte1_vld", hdl_tvaild, 3'b010);
        chk("t1 byte1_dat", hdl_tdata, 8'hBB);
        chk("t1 busy_at_done", busy, 1);
        step(); s_axis_tvaild = 1'b0; cmd_done = 3'b000; exp_count++;
        #1 chk("t1 busy_after", busy, 0);
        chk("t1 count", cmd_count, exp_count);

        // Backpressure from handler 1 with spurious done on other handlers.
        step(); s_axis_tvaild = 1'b1; s_axis_tdata = 8'h06; hdl_tready = 3'b000;
        step(); s_axis_tdata = 8'h33;
        for (int c = 0; c < 10; c++) begin
            step(); cmd_done = (c % 2 == 0) ? 3'b001 : 3'b100;
            #1 chk($sformatf("t4 stall_rdy[%0d]", c), s_axis_tready, 0);
            chk($sformatf("t4 stall_busy[%0d]", c), busy, 1);
            chk($sformatf("t4 stall_vld[%0d]", c), hdl_tvaild, 3'b010);
        end
        step(); cmd_done = 3'b010; hdl_tready = 3'b010;
        #1 chk("t4 release_rdy", s_axis_tready, 1);
        chk("t4 release_dat", hdl_tdata, 8'h33);
        step(); s_axis_tvaild = 1'b0; cmd_done = 3'b000; hdl_tready = 3'b000; exp_count++;
        #1 chk("t4 busy_after", busy, 0);
        chk("t4 count", cmd_count, exp_count);

        // Handler 0 never finishes.
        step(); s_axis_tvaild = 1'b1; s_axis_tdata = 8'h00;
        step(); s_axis_tvaild = 1'b0;
        #1 chk("t5 start", cmd_start, 3'b001);
`ifdef DAP_DISPATCH_TIMEOUT_EN
        for (int c = 1; c <= 20; c++) begin
            step();
            #1 chk($sformatf("t5 err_timeout[%0d]", c), err_timeout, (c == 20) ? 1 : 0);
            chk($sformatf("t5 abort[%0d]", c), cmd_abort, (c == 20) ? 3'b001 : 3'b000);
        end
        step();
        #1 chk("t5 idle_after_abort", busy, 0);
        chk("t5 count_unchanged", cmd_count, exp_count);
`else
        for (int c = 0; c < 1000; c++) step();
        #1 chk("t5 still_busy", busy, 1);
        chk("t5 no_abort", cmd_abort, 0);
        chk("t5 no_err", err_timeout, 0);
        step(); cmd_done = 3'b001;
        step(); cmd_done = 3'b000; exp_count++;
        #1 chk("t5 busy_after", busy, 0);
        chk("t5 count", cmd_count, exp_count);
`endif

        // Randomized traffic against a protocol-level handler/FIFO model.
        for (int c = 0; c < 60; c++) begin
            logic [7:0] pool[9];
            logic [7:0] id;
            pool = '{8'h05, 8'h06, 8'h08, 8'h12, 8'h1D, 8'h00, 8'h8F, 8'hFF, 8'h00};
            id = pool[$urandom_range(8)];
            if (c % 7 == 3) id = 8'($urandom_range(255));
            len = $urandom_range(4);
            ids.push_back(id);
            lens.push_back(len);
            stream.push_back(id);
            for (int b = 0; b < len; b++) stream.push_back(8'($urandom_range(255)));
        end
        ptr = 0; k = 0; owner = 0; rcvd = 0; stall = 0; completed = 0;
        running = 1'b0; expect_start = 1'b0;
        for (int cyc = 0; cyc < 20000 && completed < 60; cyc++) begin
            step();
            s_axis_tvaild = (ptr < stream.size()) && ($urandom_range(3) != 0 || stall >= 8);
            s_axis_tdata  = (ptr < stream.size()) ? stream[ptr] : 8'($urandom_range(255));
            hdl_tready    = 3'($urandom_range(7));
            cmd_done      = 3'b000;
            if (running) begin
                if (stall >= 8) hdl_tready[owner] = 1'b1;
                if (rcvd == lens[k]) hdl_tready[owner] = 1'b0;
                if ($urandom_range(3) == 0) cmd_done = 3'($urandom_range(7)) & ~oh(owner);
                if (rcvd == lens[k] && ($urandom_range(1) == 0 || stall >= 8))
                    cmd_done[owner] = 1'b1;
                else if (rcvd == lens[k] - 1 && s_axis_tvaild && hdl_tready[owner] && $urandom_range(1) == 1)
                    cmd_done[owner] = 1'b1;
            end else if ($urandom_range(3) == 0) begin
                cmd_done = 3'($urandom_range(7));
            end
            #1;
            if (expect_start) begin
                chk("rnd start", cmd_start, oh(owner));
                chk("rnd cmd_id", cmd_id, ids[k]);
                chk("rnd start_rdy", s_axis_tready, 0);
                chk("rnd start_vld", hdl_tvaild, 0);
                expect_start = 1'b0; running = 1'b1; rcvd = 0; stall = 0;
            end else if (running) begin
                chk("rnd run_vld", hdl_tvaild, s_axis_tvaild ? oh(owner) : 3'b000);
                chk("rnd run_rdy", s_axis_tready, hdl_tready[owner]);
                chk("rnd run_sel", active_sel, owner);
                chk("rnd run_err", err_timeout, 0);
                if (s_axis_tvaild && hdl_tready[owner]) begin
                    chk("rnd payload", hdl_tdata, stream[ptr]);
                    ptr++; rcvd++; stall = 0;
                end else begin
                    stall++;
                end
                if (cmd_done[owner]) begin
                    running = 1'b0; completed++; exp_count++; k++;
                end
            end else begin
                chk("rnd idle_busy", busy, 0);
                chk("rnd idle_rdy", s_axis_tready, 1);
                chk("rnd idle_vld", hdl_tvaild, 0);
                chk("rnd idle_sel", active_sel, 0);
                chk("rnd idle_count", cmd_count, 16'(exp_count));
                if (s_axis_tvaild) begin
                    owner = ref_sel(ids[k]);
                    expect_start = 1'b1;
                    ptr++;
                end
            end
        end
        chk("rnd all_completed", completed, 60);
        step(); s_axis_tvaild = 1'b0; cmd_done = 3'b000; hdl_tready = 3'b000;

        // Asynchronous reset in the middle of a TransferBlock.
        step(); s_axis_tvaild = 1'b1; s_axis_tdata = 8'h06; hdl_tready = 3'b010;
        step(); s_axis_tdata = 8'h44;
        step();
        #1 chk("t6 in_run", hdl_tvaild, 3'b010);
        #2 resetn = 1'b0;
        #1 chk("t6 rst_busy", busy, 0);
        chk("t6 rst_vld", hdl_tvaild, 0);
        chk("t6 rst_rdy", s_axis_tready, 1);
        chk("t6 rst_count", cmd_count, 0);
        exp_count = 0;
        step(); resetn = 1'b1; s_axis_tdata = 8'h12;
        step(); s_axis_tvaild = 1'b0;
        #1 chk("t6 new_start", cmd_start, 3'b100);
        chk("t6 new_id", cmd_id, 8'h12);
        step(); cmd_done = 3'b100;
        step(); cmd_done = 3'b000; exp_count++;
        #1 chk("t6 count", cmd_count, exp_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
